// File: rtl/scc_mixer_pkg.sv
// Shared helpers and slot constants for the N-channel stereo wave-table mixer.
package scc_mixer_pkg;

    localparam int unsigned SLOT_FRAME = 0;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r++;
        end
        return r;
    endfunction

    // First of the two drain slots that follow the last channel slot
    function automatic int unsigned slot_drain0(input int unsigned num_ch);
        return num_ch + 1;
    endfunction

    function automatic int unsigned acc_width(input int unsigned sample_w, input int unsigned num_ch);
        return (clog2(num_ch) == 0) ? sample_w + 1 : sample_w + clog2(num_ch);
    endfunction

endpackage

// File: rtl/scc_mixer_scale.sv
// Registered stage 2: volume multiply, enable/pan gating and optional midpoint offset per side.
module scc_mixer_scale
    import scc_mixer_pkg::*;
#(
    parameter int unsigned NUM_CH     = 5,
    parameter int unsigned SAMPLE_W   = 8,
    parameter int unsigned VOL_W      = 4,
    parameter int unsigned ADD_OFFSET = 1,
    parameter int unsigned TAG_W      = 3
) (
    input  logic                    clk,
    input  logic                    nreset,
    input  logic                    capture,
    input  logic [TAG_W-1:0]        tag,
    input  logic [SAMPLE_W-1:0]     wave,
    input  logic [NUM_CH*VOL_W-1:0] reg_volume,
    input  logic [NUM_CH-1:0]       reg_enable,
    input  logic [NUM_CH-1:0]       reg_pan_left,
    input  logic [NUM_CH-1:0]       reg_pan_right,
    output logic                    valid,
    output logic [SAMPLE_W-1:0]     contrib_left,
    output logic [SAMPLE_W-1:0]     contrib_right
);

    localparam int unsigned PROD_W = SAMPLE_W + VOL_W + 1;
    localparam logic [SAMPLE_W-1:0] OFFSET =
        (ADD_OFFSET != 0) ? (SAMPLE_W'(1) << (SAMPLE_W - 1)) : '0;

    logic [VOL_W-1:0]         vol_c;
    logic                     en_c;
    logic                     pan_l_c;
    logic                     pan_r_c;
    logic signed [PROD_W-1:0] wave_x_c;
    logic signed [PROD_W-1:0] vol_x_c;
    logic signed [PROD_W-1:0] prod_c;
    logic [SAMPLE_W-1:0]      scaled_c;
    logic [SAMPLE_W-1:0]      left_c;
    logic [SAMPLE_W-1:0]      right_c;

    // Per-channel register select, signed scale with floor shift, gate, offset
    always_comb begin
        vol_c   = '0;
        en_c    = 1'b0;
        pan_l_c = 1'b0;
        pan_r_c = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (tag == TAG_W'(i)) begin
                vol_c   = reg_volume[i*VOL_W +: VOL_W];
                en_c    = reg_enable[i];
                pan_l_c = reg_pan_left[i];
                pan_r_c = reg_pan_right[i];
            end
        end
        wave_x_c = PROD_W'($signed(wave));
        vol_x_c  = PROD_W'(vol_c);
        prod_c   = wave_x_c * vol_x_c;
        scaled_c = SAMPLE_W'(prod_c >>> VOL_W);
        left_c   = ((en_c && pan_l_c) ? scaled_c : '0) + OFFSET;
        right_c  = ((en_c && pan_r_c) ? scaled_c : '0) + OFFSET;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            valid         <= 1'b0;
            contrib_left  <= '0;
            contrib_right <= '0;
        end else begin
            valid         <= capture;
            contrib_left  <= left_c;
            contrib_right <= right_c;
        end
    end

endmodule

// File: rtl/scc_stereo_mixer_n.sv
// N-channel wave-table stereo mixer: slot sequencer, RAM capture pipeline and frame accumulators.
module scc_stereo_mixer_n
    import scc_mixer_pkg::*;
#(
    parameter int unsigned NUM_CH     = 5,
    parameter int unsigned SAMPLE_W   = 8,
    parameter int unsigned VOL_W      = 4,
    parameter int unsigned ADD_OFFSET = 1,
    parameter int unsigned ACC_W      = acc_width(SAMPLE_W, NUM_CH),
    parameter int unsigned SLOT_W     = clog2(NUM_CH + 3)
) (
    input  logic                    clk,
    input  logic                    nreset,
    input  logic                    bus_busy,
    output logic [SLOT_W-1:0]       slot,
    input  logic [SAMPLE_W-1:0]     wave_q,
    input  logic [NUM_CH*VOL_W-1:0] reg_volume,
    input  logic [NUM_CH-1:0]       reg_enable,
    input  logic [NUM_CH-1:0]       reg_pan_left,
    input  logic [NUM_CH-1:0]       reg_pan_right,
    output logic [ACC_W-1:0]        left_out,
    output logic [ACC_W-1:0]        right_out,
    output logic                    out_valid
);

    localparam int unsigned TAG_W = (clog2(NUM_CH) > 0) ? clog2(NUM_CH) : 1;
    localparam logic [SLOT_W-1:0] FRAME_SLOT   = SLOT_W'(SLOT_FRAME);
    localparam logic [SLOT_W-1:0] LAST_CH_SLOT = SLOT_W'(NUM_CH);
    localparam logic [SLOT_W-1:0] LAST_SLOT    = SLOT_W'(slot_drain0(NUM_CH) + 1);

    logic                issue_c;
    logic                frame_c;
    logic                issue_d;
    logic [TAG_W-1:0]    tag_d;
    logic                s2_valid;
    logic [SAMPLE_W-1:0] contrib_left;
    logic [SAMPLE_W-1:0] contrib_right;
    logic [ACC_W-1:0]    ext_left_c;
    logic [ACC_W-1:0]    ext_right_c;
    logic [ACC_W-1:0]    acc_left;
    logic [ACC_W-1:0]    acc_right;
    logic                primed;

    assign issue_c = !bus_busy && (slot != FRAME_SLOT) && (slot <= LAST_CH_SLOT);
    assign frame_c = !bus_busy && (slot == FRAME_SLOT);

    // Sequencer and stage 1; only the slot counter honours bus_busy
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            slot    <= '0;
            issue_d <= 1'b0;
            tag_d   <= '0;
        end else begin
            if (!bus_busy) begin
                slot <= (slot == LAST_SLOT) ? '0 : slot + SLOT_W'(1);
            end
            issue_d <= issue_c;
            tag_d   <= TAG_W'(slot - SLOT_W'(1));
        end
    end

    scc_mixer_scale #(
        .NUM_CH     (NUM_CH),
        .SAMPLE_W   (SAMPLE_W),
        .VOL_W      (VOL_W),
        .ADD_OFFSET (ADD_OFFSET),
        .TAG_W      (TAG_W)
    ) u_scale (
        .clk           (clk),
        .nreset        (nreset),
        .capture       (issue_d),
        .tag           (tag_d),
        .wave          (wave_q),
        .reg_volume    (reg_volume),
        .reg_enable    (reg_enable),
        .reg_pan_left  (reg_pan_left),
        .reg_pan_right (reg_pan_right),
        .valid         (s2_valid),
        .contrib_left  (contrib_left),
        .contrib_right (contrib_right)
    );

    always_comb begin
        ext_left_c  = '0;
        ext_right_c = '0;
        if (ADD_OFFSET != 0) begin
            ext_left_c  = ACC_W'(contrib_left);
            ext_right_c = ACC_W'(contrib_right);
        end else begin
            ext_left_c  = ACC_W'($signed(contrib_left));
            ext_right_c = ACC_W'($signed(contrib_right));
        end
    end

    // The first slot-0 edge after reset only arms the latch, so no empty frame is emitted
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            acc_left  <= '0;
            acc_right <= '0;
            left_out  <= '0;
            right_out <= '0;
            out_valid <= 1'b0;
            primed    <= 1'b0;
        end else if (frame_c) begin
            if (primed) begin
                left_out  <= acc_left;
                right_out <= acc_right;
            end
            out_valid <= primed;
            primed    <= 1'b1;
            acc_left  <= '0;
            acc_right <= '0;
        end else begin
            out_valid <= 1'b0;
            if (s2_valid) begin
                acc_left  <= acc_left + ext_left_c;
                acc_right <= acc_right + ext_right_c;
            end
        end
    end

endmodule

// File: tb/tb_scc_stereo_mixer_n.sv
// Directed bench for scc_stereo_mixer_n: unsigned/signed 5-channel instances and a 1-channel instance.
module tb_scc_stereo_mixer_n;

    logic        clk = 1'b0;
    logic        nreset;
    logic        bus_busy;
    logic        busy1;
    logic [2:0]  slot;
    logic [2:0]  slot_s;
    logic [1:0]  slot1;
    logic [7:0]  wave_q;
    logic [7:0]  wave_q1;
    logic [7:0]  mem [5];
    logic [7:0]  mem1;
    logic [19:0] volume;
    logic [4:0]  enable;
    logic [4:0]  pan_l;
    logic [4:0]  pan_r;
    logic [3:0]  volume1;
    logic        enable1;
    logic        pan_l1;
    logic        pan_r1;
    logic [10:0] left_out;
    logic [10:0] right_out;
    logic [10:0] left_s;
    logic [10:0] right_s;
    logic [8:0]  left1;
    logic [8:0]  right1;
    logic        out_valid;
    logic        valid_s;
    logic        valid1;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          t_prev;
    int          t_now;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Wave RAM models: address sampled on the issue edge, data held until the next issue
    always @(posedge clk) begin
        if (!bus_busy && slot >= 3'd1 && slot <= 3'd5) wave_q <= mem[slot - 3'd1];
    end
    always @(posedge clk) begin
        if (!busy1 && slot1 == 2'd1) wave_q1 <= mem1;
    end

    scc_stereo_mixer_n u_dut (
        .clk (clk), .nreset (nreset), .bus_busy (bus_busy), .slot (slot), .wave_q (wave_q),
        .reg_volume (volume), .reg_enable (enable), .reg_pan_left (pan_l), .reg_pan_right (pan_r),
        .left_out (left_out), .right_out (right_out), .out_valid (out_valid)
    );

    scc_stereo_mixer_n #(.ADD_OFFSET(0)) u_dut_s (
        .clk (clk), .nreset (nreset), .bus_busy (bus_busy), .slot (slot_s), .wave_q (wave_q),
        .reg_volume (volume), .reg_enable (enable), .reg_pan_left (pan_l), .reg_pan_right (pan_r),
        .left_out (left_s), .right_out (right_s), .out_valid (valid_s)
    );

    scc_stereo_mixer_n #(.NUM_CH(1)) u_dut1 (
        .clk (clk), .nreset (nreset), .bus_busy (busy1), .slot (slot1), .wave_q (wave_q1),
        .reg_volume (volume1), .reg_enable (enable1), .reg_pan_left (pan_l1), .reg_pan_right (pan_r1),
        .left_out (left1), .right_out (right1), .out_valid (valid1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_strobe(input int which, output int t);
        t = -1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if ((which == 0 && out_valid) || (which == 1 && valid1)) begin
                t = cyc;
                break;
            end
        end
        check("strobe_seen", 32'(t >= 0), 32'd1);
    endtask

    task automatic wait_slot(input logic [2:0] s);
        int found = 0;
        for (int i = 0; i < 30; i++) begin
            if (slot == s) begin
                found = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("slot_reached", 32'(found), 32'd1);
    endtask

    task automatic set_all(input logic [7:0] w);
        for (int i = 0; i < 5; i++) mem[i] = w;
        volume = '1;
        enable = '1;
        pan_l  = '1;
        pan_r  = '1;
    endtask

    initial begin
        nreset   = 1'b0;
        bus_busy = 1'b0;
        busy1    = 1'b0;
        set_all(8'h40);
        mem1     = 8'h10;
        volume1  = 4'd8;
        enable1  = 1'b1;
        pan_l1   = 1'b1;
        pan_r1   = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_slot", 32'(slot), 32'd0);
        check("rst_left", 32'(left_out), 32'd0);
        check("rst_right", 32'(right_out), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_left1", 32'(left1), 32'd0);

        // Full-volume 0x40 on all channels: 5*(60+128) unsigned, 5*60 signed
        nreset = 1'b1;
        t_prev = cyc;
        wait_strobe(0, t_now);
        check("first_latency", 32'((t_now - t_prev) == 8 || (t_now - t_prev) == 9), 32'd1);
        check("f1_left", 32'(left_out), 32'd940);
        check("f1_right", 32'(right_out), 32'd940);
        check("f1_left_signed", 32'(left_s), 32'd300);
        check("f1_right_signed", 32'(right_s), 32'd300);
        t_prev = t_now;
        wait_strobe(0, t_now);
        check("period_8", 32'(t_now - t_prev), 32'd8);
        check("f2_left", 32'(left_out), 32'd940);
        @(posedge clk);
        #1;
        check("strobe_one_cycle", 32'(out_valid), 32'd0);
        check("hold_left", 32'(left_out), 32'd940);
        t_prev = t_now;
        wait_strobe(0, t_now);
        check("period_8b", 32'(t_now - t_prev), 32'd8);

        // ch0 0x7F left only, ch1-4 disabled: muted sides contribute the midpoint
        mem[0] = 8'h7F;
        enable = 5'b00001;
        pan_r  = 5'b11110;
        t_prev = t_now;
        wait_strobe(0, t_now);
        check("pan_period", 32'(t_now - t_prev), 32'd8);
        check("pan_left", 32'(left_out), 32'd759);
        check("pan_right", 32'(right_out), 32'd640);
        check("pan_left_signed", 32'(left_s), 32'd119);
        check("pan_right_signed", 32'(right_s), 32'd0);

        // Most negative sample: each contribution -120, sum -600 in 11 bits
        set_all(8'h80);
        wait_strobe(0, t_now);
        check("neg_left_signed", 32'(left_s), 32'h5A8);
        check("neg_right_signed", 32'(right_s), 32'h5A8);
        check("neg_left_unsigned", 32'(left_out), 32'd40);

        // Stall 3 cycles at slot 3 and 2 cycles at slot 0
        set_all(8'h40);
        wait_strobe(0, t_prev);
        check("pre_stall_left", 32'(left_out), 32'd940);
        wait_slot(3'd3);
        bus_busy = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("stall_slot3", 32'(slot), 32'd3);
        end
        bus_busy = 1'b0;
        wait_slot(3'd0);
        bus_busy = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("stall_slot0", 32'(slot), 32'd0);
            check("stall_no_valid", 32'(out_valid), 32'd0);
        end
        bus_busy = 1'b0;
        wait_strobe(0, t_now);
        check("stall_period", 32'(t_now - t_prev), 32'd13);
        check("stall_left", 32'(left_out), 32'd940);
        check("stall_right", 32'(right_out), 32'd940);
        check("stall_left_signed", 32'(left_s), 32'd300);

        // Reset mid-frame clears immediately; next frame is complete
        wait_slot(3'd4);
        nreset = 1'b0;
        #1;
        check("midrst_slot", 32'(slot), 32'd0);
        check("midrst_left", 32'(left_out), 32'd0);
        check("midrst_right", 32'(right_out), 32'd0);
        check("midrst_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        nreset = 1'b1;
        t_prev = cyc;
        wait_strobe(0, t_now);
        check("midrst_latency", 32'((t_now - t_prev) == 8 || (t_now - t_prev) == 9), 32'd1);
        check("midrst_frame_left", 32'(left_out), 32'd940);
        check("midrst_frame_right", 32'(right_out), 32'd940);

        // Single channel: vol 8, wave 0x10 -> 8 + 128
        wait_strobe(1, t_prev);
        check("ch1_left", 32'(left1), 32'd136);
        check("ch1_right", 32'(right1), 32'd136);
        wait_strobe(1, t_now);
        check("ch1_period", 32'(t_now - t_prev), 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
